cache_refill_arbiter: RTL and testbench
=======================================

# cache_refill_arbiter

Shares the single external memory port between I-cache refills and D-cache refills/writebacks. Sits between both caches and the memory interface, below the stall/flush logic: each cache holds its miss (`valid`/`done` low) until this block completes its burst. D-cache has fixed priority, since a D-miss stalls the whole pipeline. A starvation counter guarantees I-cache progress under a continuous stream of D-cache traffic.

## Interface
- `ADDR_WIDTH`, 26, line address width (word address bits above the burst offset).
- `DATA_WIDTH`, 32, beat width.
- `BURST_LEN`, 4, beats per transaction; power of two, ≥2.
- `STARVE_LIMIT`, 2, consecutive D-grants tolerated while `ic_req` is pending; ≥1.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `ic_req` in 1, `ic_addr` in ADDR_WIDTH: I-cache line read request. Held stable until `ic_done`.
- `ic_gnt` out 1, `ic_rvalid` out 1, `ic_rdata` out DATA_WIDTH, `ic_done` out 1: grant pulse, read beats, last-beat pulse.
- `dc_req` in 1, `dc_we` in 1, `dc_addr` in ADDR_WIDTH, `dc_wdata` in DATA_WIDTH: D-cache request. Held until `dc_done`; `dc_wdata` advances on each `dc_wready`.
- `dc_gnt` out 1, `dc_rvalid` out 1, `dc_rdata` out DATA_WIDTH, `dc_wready` out 1, `dc_done` out 1.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out ADDR_WIDTH, `mem_wdata` out DATA_WIDTH: memory command and write data.
- `mem_ready` in 1: accepts the command in REQ; accepts a write beat in WRITE.
- `mem_rvalid` in 1, `mem_rdata` in DATA_WIDTH: read beats.
- `owner` out 1: 0 = I-cache, 1 = D-cache; meaningful only when `busy`.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, REQ, READ, WRITE.
- IDLE arbitration, evaluated each cycle:
  - If `dc_req` is high and (`ic_req` is low or `starve_cnt` < STARVE_LIMIT), grant D.
  - Else if `ic_req` is high, grant I.
  - On a grant: latch owner, addr, and we (we = 0 for I), go to REQ.
- `starve_cnt`: width clog2(STARVE_LIMIT+1), saturating.
  - +1 on each D grant while `ic_req` is high.
  - Cleared on an I grant or when `ic_req` is low in IDLE.
- REQ:
  - `mem_req`=1; `mem_addr` and `mem_we` come from the latches.
  - Owner `*_gnt`=1 in the first REQ cycle only.
  - When `mem_ready` is high: go to READ if we=0, else go to WRITE. Beat counter cleared.
- READ:
  - Each `mem_rvalid` beat is passed through combinationally to the owner's `*_rvalid`/`*_rdata`, and the counter increments.
  - The beat with counter = BURST_LEN−1 also asserts owner `*_done`; state goes to IDLE.
- WRITE:
  - `mem_wdata`=`dc_wdata`; `dc_wready`=`mem_ready`.
  - Each `mem_ready` beat increments the counter; the last beat asserts `dc_done`; state goes to IDLE.
- `mem_rvalid` outside READ is ignored. `mem_ready` outside REQ/WRITE is ignored.
- Non-owner outputs stay 0 throughout a transaction.

## Timing
- Reset: state IDLE, `starve_cnt`=0, beat counter 0. All outputs 0, including `mem_req`, `busy`, `owner`, all gnt/rvalid/done/wready, and `mem_addr`/`mem_wdata`/`*_rdata` zero-driven.
- Reset mid-transaction aborts it immediately, with no `done`. Beats arriving after reset are dropped.
- Grant latency: request high in IDLE at cycle t → REQ with `mem_req` and `*_gnt` at t+1.
- Read completion: `*_done` is coincident with the final `mem_rvalid`. Earliest next arbitration is the following cycle (one IDLE cycle minimum between transactions).
- Minimum read: 1 IDLE + 1 REQ + BURST_LEN READ cycles, with zero wait states.
- Requesters may drop `*_req` in the cycle after `*_done`. A `*_req` still high in IDLE is treated as a new request.
- `ic_req` and `dc_req` rising in the same IDLE cycle follow the arbitration rule. There is no preemption once in REQ.
- A `*_req` deasserted while not granted is a protocol error; behaviour is undefined and not checked.

## Test plan
- I-read, zero-wait memory, `ic_addr`=0x100, beats 0xA0..0xA3 → `ic_gnt` at t+1; 4 `ic_rvalid` carrying 0xA0..0xA3; `ic_done` on 0xA3; `busy` low the next cycle.
- D-write, `dc_addr`=0x200, `mem_ready` toggling 1,0,1,0,… → exactly 4 `dc_wready` pulses with `mem_wdata` matching `dc_wdata`; `dc_done` on the 4th; `mem_we`=1 throughout.
- `ic_req` and `dc_req` held continuously, STARVE_LIMIT=2 → grant order D, D, I, D, D, I; `starve_cnt` is 0 after each I grant.
- Simultaneous first requests, `ic_req` then dropped after `ic_done` while `dc_req` persists → D first, I second, then D back-to-back with one IDLE cycle between.
- `rst` pulsed after the 2nd read beat, with stray `mem_rvalid` afterwards → no `done`; all outputs 0 in the cycle after reset; stray beats produce no `*_rvalid`; the next request is granted normally.
- `mem_ready` held low for 5 cycles in REQ → `mem_req` and address stable all 5 cycles; `*_gnt` asserted only in the first.

Source files
------------

// File: rtl/cache_refill_arbiter.sv
// Shares one burst memory port between I-cache refills and D-cache refills/writebacks.
// D-cache wins arbitration, but a starvation counter forces an I-grant after STARVE_LIMIT D-grants.
module cache_refill_arbiter #(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_LEN    = 4,
    parameter int STARVE_LIMIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_gnt,
    output logic                  ic_rvalid,
    output logic [DATA_WIDTH-1:0] ic_rdata,
    output logic                  ic_done,
    input  logic                  dc_req,
    input  logic                  dc_we,
    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic [DATA_WIDTH-1:0] dc_wdata,
    output logic                  dc_gnt,
    output logic                  dc_rvalid,
    output logic [DATA_WIDTH-1:0] dc_rdata,
    output logic                  dc_wready,
    output logic                  dc_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  owner,
    output logic                  busy
);

    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, REQ, READ, WRITE} state_t;

    state_t                state;
    state_t                state_next;
    logic                  owner_q;
    logic                  we_q;
    logic                  first_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      starve_cnt;
    logic [BEAT_W-1:0]     beat_cnt;
    logic                  grant_d;
    logic                  grant_i;
    logic                  last_beat;

    always_comb begin
        grant_d   = dc_req && (!ic_req || (starve_cnt < STARVE_MAX));
        grant_i   = !grant_d && ic_req;
        last_beat = (beat_cnt == LAST_BEAT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            first_q    <= 1'b0;
            addr_q     <= '0;
            starve_cnt <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_q <= 1'b1;
                        we_q    <= dc_we;
                        addr_q  <= dc_addr;
                        first_q <= 1'b1;
                        if (ic_req && (starve_cnt != STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (grant_i) begin
                        owner_q    <= 1'b0;
                        we_q       <= 1'b0;
                        addr_q     <= ic_addr;
                        first_q    <= 1'b1;
                        starve_cnt <= '0;
                    end
                    if (!ic_req) begin
                        starve_cnt <= '0;
                    end
                end
                REQ: begin
                    first_q <= 1'b0;
                    if (mem_ready) begin
                        beat_cnt <= '0;
                    end
                end
                READ: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low while rst is high so a reset aborts a burst in the same cycle.
    always_comb begin
        state_next = state;
        ic_gnt     = 1'b0;
        ic_rvalid  = 1'b0;
        ic_rdata   = '0;
        ic_done    = 1'b0;
        dc_gnt     = 1'b0;
        dc_rvalid  = 1'b0;
        dc_rdata   = '0;
        dc_wready  = 1'b0;
        dc_done    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b0;
        owner      = 1'b0;
        if (!rst) begin
            busy  = (state != IDLE);
            owner = (state != IDLE) && owner_q;
            case (state)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        state_next = REQ;
                    end
                end
                REQ: begin
                    mem_req  = 1'b1;
                    mem_we   = we_q;
                    mem_addr = addr_q;
                    ic_gnt   = first_q && !owner_q;
                    dc_gnt   = first_q && owner_q;
                    if (mem_ready) begin
                        state_next = we_q ? WRITE : READ;
                    end
                end
                READ: begin
                    mem_addr = addr_q;
                    if (mem_rvalid) begin
                        if (owner_q) begin
                            dc_rvalid = 1'b1;
                            dc_rdata  = mem_rdata;
                            dc_done   = last_beat;
                        end else begin
                            ic_rvalid = 1'b1;
                            ic_rdata  = mem_rdata;
                            ic_done   = last_beat;
                        end
                        if (last_beat) begin
                            state_next = IDLE;
                        end
                    end
                end
                WRITE: begin
                    mem_we    = we_q;
                    mem_addr  = addr_q;
                    mem_wdata = dc_wdata;
                    dc_wready = mem_ready;
                    if (mem_ready && last_beat) begin
                        dc_done    = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed self-checking bench for cache_refill_arbiter with default parameters.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_cache_refill_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req;
    logic [25:0] ic_addr;
    logic        ic_gnt, ic_rvalid, ic_done;
    logic [31:0] ic_rdata;
    logic        dc_req, dc_we;
    logic [25:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_gnt, dc_rvalid, dc_wready, dc_done;
    logic [31:0] dc_rdata;
    logic        mem_req, mem_we;
    logic [25:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        owner, busy;

    int testCount = 0;
    int failCount = 0;

    cache_refill_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
        .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
        .dc_wready(dc_wready), .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic rvalid, input logic [31:0] rdata);
        mem_ready  = ready;
        mem_rvalid = rvalid;
        mem_rdata  = rdata;
        #1;
    endtask

    // Entered in the first REQ cycle; returns in the IDLE cycle after the last beat.
    task automatic runRead(input logic expD, input logic [31:0] base, input string tag);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput({tag, "_gnt"}, expD ? dc_gnt : ic_gnt, 1);
        checkOutput({tag, "_other_gnt"}, expD ? ic_gnt : dc_gnt, 0);
        checkOutput({tag, "_owner"}, owner, expD);
        checkOutput({tag, "_mem_req"}, mem_req, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b1, base + 32'(i));
            checkOutput({tag, "_rvalid"}, expD ? dc_rvalid : ic_rvalid, 1);
            checkOutput({tag, "_rdata"}, expD ? dc_rdata : ic_rdata, base + 32'(i));
            checkOutput({tag, "_done"}, expD ? dc_done : ic_done, (i == 3));
            checkOutput({tag, "_other_rvalid"}, expD ? ic_rvalid : dc_rvalid, 0);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput({tag, "_idle_after"}, busy, 0);
    endtask

    initial begin
        int wreadyCount;
        int beat;
        logic doneSeen;

        rst = 1'b1;
        ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_mem_req", mem_req, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_owner", owner, 0);
        checkOutput("reset_starve", dut.starve_cnt, 0);

        // I-cache read at 0x100 with zero-wait memory
        ic_req = 1'b1; ic_addr = 26'h100;
        #1;
        checkOutput("iread_no_gnt_yet", ic_gnt, 0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("iread_addr", mem_addr, 26'h100);
        checkOutput("iread_we", mem_we, 0);
        checkOutput("iread_busy", busy, 1);
        runRead(1'b0, 32'hA0, "iread");
        ic_req = 1'b0;
        #1;

        // D-cache writeback at 0x200 with mem_ready toggling
        @(negedge clk);
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 26'h200; dc_wdata = 32'hD0;
        #1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("dwr_gnt", dc_gnt, 1);
        checkOutput("dwr_addr", mem_addr, 26'h200);
        checkOutput("dwr_we_req", mem_we, 1);
        wreadyCount = 0;
        beat = 0;
        doneSeen = 1'b0;
        for (int k = 0; k < 20 && !doneSeen; k++) begin
            @(negedge clk);
            dc_wdata = 32'hD0 + 32'(beat);
            applyStimulus((k % 2) == 0, 1'b0, 32'h0);
            checkOutput("dwr_wready", dc_wready, (k % 2) == 0);
            checkOutput("dwr_wdata", mem_wdata, 32'hD0 + 32'(beat));
            checkOutput("dwr_we", mem_we, 1);
            checkOutput("dwr_done", dc_done, ((k % 2) == 0) && (beat == 3));
            if (dc_wready) wreadyCount++;
            if (dc_done) doneSeen = 1'b1;
            if ((k % 2) == 0) beat++;
        end
        checkOutput("dwr_wready_count", wreadyCount, 4);
        checkOutput("dwr_done_seen", doneSeen, 1);
        @(negedge clk);
        dc_req = 1'b0; dc_we = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("dwr_idle_after", busy, 0);

        // Both held: expect D, D, I, D, D, I
        @(negedge clk);
        ic_req = 1'b1; ic_addr = 26'h111;
        dc_req = 1'b1; dc_addr = 26'h222;
        #1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            checkOutput("starve_cnt_d1", dut.starve_cnt, 1);
            runRead(1'b1, 32'h10, "starve_d1");
            @(negedge clk);
            checkOutput("starve_cnt_d2", dut.starve_cnt, 2);
            runRead(1'b1, 32'h20, "starve_d2");
            @(negedge clk);
            checkOutput("starve_cnt_i", dut.starve_cnt, 0);
            checkOutput("starve_i_addr", mem_addr, 26'h111);
            runRead(1'b0, 32'h30, "starve_i");
        end
        ic_req = 1'b0; dc_req = 1'b0;
        #1;
        @(negedge clk);

        // Simultaneous first requests: D, then I, then D again
        ic_req = 1'b1; dc_req = 1'b1;
        #1;
        @(negedge clk);
        runRead(1'b1, 32'h40, "simul_d");
        dc_req = 1'b0;
        #1;
        @(negedge clk);
        dc_req = 1'b1;
        runRead(1'b0, 32'h50, "simul_i");
        ic_req = 1'b0;
        #1;
        @(negedge clk);
        runRead(1'b1, 32'h60, "simul_d2");
        dc_req = 1'b0;
        #1;
        @(negedge clk);

        // Memory stalls the command for 5 cycles
        dc_req = 1'b1; dc_addr = 26'h3C0;
        #1;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("wait_mem_req", mem_req, 1);
            checkOutput("wait_addr", mem_addr, 26'h3C0);
            checkOutput("wait_gnt", dc_gnt, (w == 0));
        end
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wait_accept_gnt", dc_gnt, 0);
        checkOutput("wait_accept_req", mem_req, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b1, 32'h70 + 32'(i));
            checkOutput("wait_rdata", dc_rdata, 32'h70 + 32'(i));
            checkOutput("wait_done", dc_done, (i == 3));
        end
        @(negedge clk);
        dc_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Reset after the 2nd beat aborts the burst
        @(negedge clk);
        ic_req = 1'b1; ic_addr = 26'h180;
        #1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b1, 32'h80 + 32'(i));
            checkOutput("rst_pre_rvalid", ic_rvalid, 1);
        end
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h82);
        checkOutput("rst_no_done", ic_done, 0);
        @(negedge clk);
        rst = 1'b0;
        ic_req = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h83);
        checkOutput("rst_after_busy", busy, 0);
        checkOutput("rst_after_mem_req", mem_req, 0);
        checkOutput("rst_after_addr", mem_addr, 0);
        checkOutput("rst_stray_rvalid", ic_rvalid, 0);
        checkOutput("rst_stray_done", ic_done, 0);
        checkOutput("rst_stray_rdata", ic_rdata, 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h84);
        checkOutput("rst_stray2_rvalid", ic_rvalid, 0);
        ic_req = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("rst_regrant_addr", mem_addr, 26'h180);
        runRead(1'b0, 32'h90, "rst_regrant");
        ic_req = 1'b0;
        #1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
